// File: rtl/uvmt_cv32e40x_exception_trap_checker.sv
// -----------------------------------------------------------------------------
// uvmt_cv32e40x_exception_trap_checker
//
// Purpose:
//   Watches the writeback-stage exception classifier flags and turns each
//   classified exception into an expected trap (mcause code + mepc). It then
//   waits a bounded number of cycles for the core to report trap entry and
//   compares the trap against the expectation. Missed, mismatched, overlapping
//   and spurious traps are reported as registered one-cycle error pulses.
//   Matched traps are counted per cause in saturating counters so that
//   coverage closure can be tracked.
//
// Parameters:
//   TIMEOUT  maximum cycles from exception capture to trap entry (1..255)
//   CNT_W    width of each per-cause saturating counter
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   is_ibus_buserr_i        WB instruction has an instruction-bus error
//   is_instr_illegal_i      WB instruction is illegal
//   is_instr_ecall_i        WB instruction is ecall
//   is_instr_ebreak_i       WB instruction is ebreak / c.ebreak
//   wb_pc_i[31:0]           PC of the WB instruction
//   ebreak_to_debug_i       ebreak enters debug mode instead of trapping
//   trap_taken_i            core takes a trap this cycle
//   trap_mcause_i[31:0]     mcause written by the trap
//   trap_mepc_i[31:0]       mepc written by the trap
//   pending_o               an exception is awaiting trap entry
//   exp_cause_o[4:0]        expected exception code while pending, else 0
//   err_missed_o            pulse: timeout expired with no trap
//   err_mismatch_o          pulse: trap with wrong cause or mepc
//   err_overlap_o           pulse: new exception arrived while pending
//   err_spurious_o          pulse: synchronous trap with nothing pending
//   cnt_*_o[CNT_W-1:0]      per-cause counts of matched traps (saturating)
//
// Optional feature (macro UVMT_CV32E40X_EXC_TRAP_CHECKER_ASSERT_EN):
//   When defined, concurrent assertions report every error pulse with cause
//   and PC, an invariant checks that a capture never happens while pending,
//   and cover properties track a match for every cause.
// -----------------------------------------------------------------------------
module uvmt_cv32e40x_exception_trap_checker #(
  parameter int unsigned TIMEOUT = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             is_ibus_buserr_i,
  input  logic             is_instr_illegal_i,
  input  logic             is_instr_ecall_i,
  input  logic             is_instr_ebreak_i,
  input  logic [31:0]      wb_pc_i,
  input  logic             ebreak_to_debug_i,
  input  logic             trap_taken_i,
  input  logic [31:0]      trap_mcause_i,
  input  logic [31:0]      trap_mepc_i,
  output logic             pending_o,
  output logic [4:0]       exp_cause_o,
  output logic             err_missed_o,
  output logic             err_mismatch_o,
  output logic             err_overlap_o,
  output logic             err_spurious_o,
  output logic [CNT_W-1:0] cnt_buserr_o,
  output logic [CNT_W-1:0] cnt_illegal_o,
  output logic [CNT_W-1:0] cnt_ecall_o,
  output logic [CNT_W-1:0] cnt_ebreak_o
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

  localparam logic [4:0] CAUSE_BUSERR  = 5'd1;
  localparam logic [4:0] CAUSE_ILLEGAL = 5'd2;
  localparam logic [4:0] CAUSE_EBREAK  = 5'd3;
  localparam logic [4:0] CAUSE_ECALL   = 5'd11;

  // Timer value on which the last legal trap cycle falls.
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : (v + CNT_W'(1));
  endfunction

  // A trap matches when the exception code and mepc agree and no stray bits
  // are set in the upper (non-interrupt) part of mcause.
  function automatic logic trap_matches(input logic [31:0] mcause,
                                        input logic [31:0] mepc,
                                        input logic [4:0]  cause,
                                        input logic [31:0] pc);
    return (mcause[4:0] == cause) && (mcause[30:5] == 26'd0) && (mepc == pc);
  endfunction

  state_e           r_state;
  state_e           w_state_nxt;
  logic [4:0]       r_exp_cause;
  logic [31:0]      r_exp_pc;
  logic [7:0]       r_timer;

  logic             r_err_missed;
  logic             r_err_mismatch;
  logic             r_err_overlap;
  logic             r_err_spurious;

  logic [CNT_W-1:0] r_cnt_buserr;
  logic [CNT_W-1:0] r_cnt_illegal;
  logic [CNT_W-1:0] r_cnt_ecall;
  logic [CNT_W-1:0] r_cnt_ebreak;

  logic             w_ebreak_qual;
  logic             w_flag;
  logic [4:0]       w_new_cause;
  logic             w_sync_trap;

  logic             w_capture;
  logic             w_cnt_en;
  logic [4:0]       w_cnt_cause;
  logic             w_missed_nxt;
  logic             w_mismatch_nxt;
  logic             w_overlap_nxt;
  logic             w_spurious_nxt;

  // An ebreak that goes to debug mode never produces a trap, so it is not
  // treated as an exception at all.
  assign w_ebreak_qual = is_instr_ebreak_i & ~ebreak_to_debug_i;
  assign w_flag        = is_ibus_buserr_i | is_instr_illegal_i |
                         is_instr_ecall_i | w_ebreak_qual;

  always_comb begin
    w_new_cause = 5'd0;
    if (is_ibus_buserr_i) begin
      w_new_cause = CAUSE_BUSERR;
    end else if (is_instr_illegal_i) begin
      w_new_cause = CAUSE_ILLEGAL;
    end else if (w_ebreak_qual) begin
      w_new_cause = CAUSE_EBREAK;
    end else if (is_instr_ecall_i) begin
      w_new_cause = CAUSE_ECALL;
    end
  end

  // Interrupts (mcause[31]=1) are asynchronous and outside this checker.
  assign w_sync_trap = trap_taken_i & ~trap_mcause_i[31];

  always_comb begin
    w_state_nxt    = r_state;
    w_capture      = 1'b0;
    w_cnt_en       = 1'b0;
    w_cnt_cause    = w_new_cause;
    w_missed_nxt   = 1'b0;
    w_mismatch_nxt = 1'b0;
    w_overlap_nxt  = 1'b0;
    w_spurious_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_flag && !w_sync_trap) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_PENDING;
        end else if (w_flag && w_sync_trap) begin
          // Zero-latency trap: compare against the exception seen right now.
          if (trap_matches(trap_mcause_i, trap_mepc_i, w_new_cause, wb_pc_i)) begin
            w_cnt_en = 1'b1;
          end else begin
            w_mismatch_nxt = 1'b1;
          end
        end else if (w_sync_trap) begin
          w_spurious_nxt = 1'b1;
        end
      end

      ST_PENDING: begin
        // The captured exception is kept; a newcomer is only reported.
        w_overlap_nxt = w_flag;
        w_cnt_cause   = r_exp_cause;
        // A trap on the boundary cycle wins over the timeout.
        if (w_sync_trap) begin
          w_state_nxt = ST_IDLE;
          if (trap_matches(trap_mcause_i, trap_mepc_i, r_exp_cause, r_exp_pc)) begin
            w_cnt_en = 1'b1;
          end else begin
            w_mismatch_nxt = 1'b1;
          end
        end else if (r_timer == TIMER_LAST) begin
          w_missed_nxt = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---- state, timer and registered error pulses ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= ST_IDLE;
      r_timer        <= 8'd0;
      r_err_missed   <= 1'b0;
      r_err_mismatch <= 1'b0;
      r_err_overlap  <= 1'b0;
      r_err_spurious <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_err_missed   <= w_missed_nxt;
      r_err_mismatch <= w_mismatch_nxt;
      r_err_overlap  <= w_overlap_nxt;
      r_err_spurious <= w_spurious_nxt;
      if (w_capture) begin
        r_timer <= 8'd0;
      end else if (r_state == ST_PENDING) begin
        r_timer <= r_timer + 8'd1;
      end
    end
  end

  // ---- capture of the expected trap (data only, qualified by r_state) ----
  always_ff @(posedge clk_i) begin
    if (w_capture) begin
      r_exp_cause <= w_new_cause;
      r_exp_pc    <= wb_pc_i;
    end
  end

  // ---- per-cause saturating match counters ----
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt_buserr  <= '0;
      r_cnt_illegal <= '0;
      r_cnt_ecall   <= '0;
      r_cnt_ebreak  <= '0;
    end else if (w_cnt_en) begin
      case (w_cnt_cause)
        CAUSE_BUSERR:  r_cnt_buserr  <= sat_inc(r_cnt_buserr);
        CAUSE_ILLEGAL: r_cnt_illegal <= sat_inc(r_cnt_illegal);
        CAUSE_EBREAK:  r_cnt_ebreak  <= sat_inc(r_cnt_ebreak);
        CAUSE_ECALL:   r_cnt_ecall   <= sat_inc(r_cnt_ecall);
        default: ;
      endcase
    end
  end

  assign pending_o      = (r_state == ST_PENDING);
  assign exp_cause_o    = pending_o ? r_exp_cause : 5'd0;
  assign err_missed_o   = r_err_missed;
  assign err_mismatch_o = r_err_mismatch;
  assign err_overlap_o  = r_err_overlap;
  assign err_spurious_o = r_err_spurious;
  assign cnt_buserr_o   = r_cnt_buserr;
  assign cnt_illegal_o  = r_cnt_illegal;
  assign cnt_ecall_o    = r_cnt_ecall;
  assign cnt_ebreak_o   = r_cnt_ebreak;

`ifdef UVMT_CV32E40X_EXC_TRAP_CHECKER_ASSERT_EN
  // Cause/PC of the event behind the pulse visible in the following cycle.
  logic [4:0]  r_evt_cause;
  logic [31:0] r_evt_pc;

  always_ff @(posedge clk_i) begin
    if (r_state == ST_PENDING) begin
      r_evt_cause <= r_exp_cause;
      r_evt_pc    <= r_exp_pc;
    end else if (w_flag) begin
      r_evt_cause <= w_new_cause;
      r_evt_pc    <= wb_pc_i;
    end else begin
      r_evt_cause <= trap_mcause_i[4:0];
      r_evt_pc    <= trap_mepc_i;
    end
  end

  a_no_missed: assert property (@(posedge clk_i) disable iff (!rst_ni) !err_missed_o)
    else $error("missed trap: cause %0d pc 0x%08h", r_evt_cause, r_evt_pc);
  a_no_mismatch: assert property (@(posedge clk_i) disable iff (!rst_ni) !err_mismatch_o)
    else $error("trap mismatch: expected cause %0d pc 0x%08h", r_evt_cause, r_evt_pc);
  a_no_overlap: assert property (@(posedge clk_i) disable iff (!rst_ni) !err_overlap_o)
    else $error("overlapping exception while pending: cause %0d pc 0x%08h", r_evt_cause, r_evt_pc);
  a_no_spurious: assert property (@(posedge clk_i) disable iff (!rst_ni) !err_spurious_o)
    else $error("spurious trap: cause %0d mepc 0x%08h", r_evt_cause, r_evt_pc);
  a_capture_not_pending: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pending_o && w_capture))
    else $error("capture while pending: cause %0d pc 0x%08h", w_new_cause, wb_pc_i);

  c_match_buserr:  cover property (@(posedge clk_i) disable iff (!rst_ni)
    w_cnt_en && (w_cnt_cause == CAUSE_BUSERR));
  c_match_illegal: cover property (@(posedge clk_i) disable iff (!rst_ni)
    w_cnt_en && (w_cnt_cause == CAUSE_ILLEGAL));
  c_match_ebreak:  cover property (@(posedge clk_i) disable iff (!rst_ni)
    w_cnt_en && (w_cnt_cause == CAUSE_EBREAK));
  c_match_ecall:   cover property (@(posedge clk_i) disable iff (!rst_ni)
    w_cnt_en && (w_cnt_cause == CAUSE_ECALL));
`endif

endmodule

// File: tb/tb_uvmt_cv32e40x_exception_trap_checker.sv
module tb_uvmt_cv32e40x_exception_trap_checker;

  localparam int TIMEOUT = 8;
  localparam int CNT_W   = 16;

  localparam logic [3:0] M_MISSED   = 4'b1000;
  localparam logic [3:0] M_MISMATCH = 4'b0100;
  localparam logic [3:0] M_OVERLAP  = 4'b0010;
  localparam logic [3:0] M_SPURIOUS = 4'b0001;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic             is_ibus_buserr = 1'b0;
  logic             is_instr_illegal = 1'b0;
  logic             is_instr_ecall = 1'b0;
  logic             is_instr_ebreak = 1'b0;
  logic [31:0]      wb_pc = 32'd0;
  logic             ebreak_to_debug = 1'b0;
  logic             trap_taken = 1'b0;
  logic [31:0]      trap_mcause = 32'd0;
  logic [31:0]      trap_mepc = 32'd0;
  logic             pending_o;
  logic [4:0]       exp_cause_o;
  logic             err_missed_o, err_mismatch_o, err_overlap_o, err_spurious_o;
  logic [CNT_W-1:0] cnt_buserr_o, cnt_illegal_o, cnt_ecall_o, cnt_ebreak_o;

  always #5 clk = ~clk;

  uvmt_cv32e40x_exception_trap_checker #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i              (clk),
    .rst_ni             (rst_ni),
    .is_ibus_buserr_i   (is_ibus_buserr),
    .is_instr_illegal_i (is_instr_illegal),
    .is_instr_ecall_i   (is_instr_ecall),
    .is_instr_ebreak_i  (is_instr_ebreak),
    .wb_pc_i            (wb_pc),
    .ebreak_to_debug_i  (ebreak_to_debug),
    .trap_taken_i       (trap_taken),
    .trap_mcause_i      (trap_mcause),
    .trap_mepc_i        (trap_mepc),
    .pending_o          (pending_o),
    .exp_cause_o        (exp_cause_o),
    .err_missed_o       (err_missed_o),
    .err_mismatch_o     (err_mismatch_o),
    .err_overlap_o      (err_overlap_o),
    .err_spurious_o     (err_spurious_o),
    .cnt_buserr_o       (cnt_buserr_o),
    .cnt_illegal_o      (cnt_illegal_o),
    .cnt_ecall_o        (cnt_ecall_o),
    .cnt_ebreak_o       (cnt_ebreak_o)
  );

  int checks = 0;
  int passed = 0;
  int n_edge = 0;

  // Expected model counters
  logic [CNT_W-1:0] m_buserr = '0, m_illegal = '0, m_ecall = '0, m_ebreak = '0;

  // Scoreboard of expected error pulses: edge number after which the pulse
  // mask is visible.
  typedef struct {
    int         due;
    logic [3:0] mask;
  } exp_t;
  exp_t sb_q[$];

  always @(posedge clk) n_edge <= n_edge + 1;

  always @(negedge clk) begin
    logic [3:0] m;
    m = {err_missed_o, err_mismatch_o, err_overlap_o, err_spurious_o};
    while (sb_q.size() > 0 && sb_q[0].due < n_edge) begin
      checks++;
      $display("FAIL pulse_never_seen due_edge=%0d got=none required=%b", sb_q[0].due, sb_q[0].mask);
      void'(sb_q.pop_front());
    end
    if (sb_q.size() > 0 && sb_q[0].due == n_edge) begin
      checks++;
      if (m !== sb_q[0].mask)
        $display("FAIL err_pulse edge=%0d got=%b required=%b", n_edge, m, sb_q[0].mask);
      else
        passed++;
      void'(sb_q.pop_front());
    end else if (m != 4'b0000) begin
      checks++;
      $display("FAIL unexpected_pulse edge=%0d got=%b required=0000", n_edge, m);
    end
  end

  task automatic expect_pulse(input int due, input logic [3:0] mask);
    exp_t e;
    int   pos;
    e.due  = due;
    e.mask = mask;
    pos    = sb_q.size();
    for (int i = 0; i < sb_q.size(); i++) begin
      if (sb_q[i].due == due) begin
        e.mask   = sb_q[i].mask | mask;
        sb_q[i]  = e;
        return;
      end
      if (sb_q[i].due > due && pos == sb_q.size()) pos = i;
    end
    sb_q.insert(pos, e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    is_ibus_buserr   = 1'b0;
    is_instr_illegal = 1'b0;
    is_instr_ecall   = 1'b0;
    is_instr_ebreak  = 1'b0;
    ebreak_to_debug  = 1'b0;
    trap_taken       = 1'b0;
    trap_mcause      = 32'd0;
    trap_mepc        = 32'd0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    clear_inputs();
    repeat (3) tick();
    checks++;
    if (pending_o !== 1'b0 || exp_cause_o !== 5'd0)
      $display("FAIL reset_pending got=%b/%0d required=0/0", pending_o, exp_cause_o);
    else passed++;
    checks++;
    if ({err_missed_o, err_mismatch_o, err_overlap_o, err_spurious_o} !== 4'b0000)
      $display("FAIL reset_errs got=%b required=0000",
               {err_missed_o, err_mismatch_o, err_overlap_o, err_spurious_o});
    else passed++;
    checks++;
    if ({cnt_buserr_o, cnt_illegal_o, cnt_ecall_o, cnt_ebreak_o} !== '0)
      $display("FAIL reset_counters got=%h/%h/%h/%h required=0",
               cnt_buserr_o, cnt_illegal_o, cnt_ecall_o, cnt_ebreak_o);
    else passed++;
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_illegal_match();
    int pend_cycles = 0;
    is_instr_illegal = 1'b1;
    wb_pc = 32'h0000_1000;
    tick();
    clear_inputs();
    checks++;
    if (exp_cause_o !== 5'd2) $display("FAIL illegal_exp_cause got=%0d required=2", exp_cause_o);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      if (pending_o) pend_cycles++;
      if (i == 2) begin
        trap_taken = 1'b1; trap_mcause = 32'd2; trap_mepc = 32'h0000_1000;
      end
      tick();
    end
    clear_inputs();
    m_illegal++;
    checks++;
    if (pend_cycles != 3) $display("FAIL illegal_pending_len got=%0d required=3", pend_cycles);
    else passed++;
    checks++;
    if (pending_o !== 1'b0) $display("FAIL illegal_back_idle got=%b required=0", pending_o);
    else passed++;
    checks++;
    if (cnt_illegal_o !== m_illegal) $display("FAIL illegal_count got=%0d required=%0d", cnt_illegal_o, m_illegal);
    else passed++;
  endtask

  task automatic test_missed();
    is_instr_ecall = 1'b1;
    wb_pc = 32'h0000_2000;
    expect_pulse(n_edge + 1 + TIMEOUT, M_MISSED);
    tick();
    clear_inputs();
    repeat (TIMEOUT) tick();
    checks++;
    if (pending_o !== 1'b0 || err_missed_o !== 1'b1)
      $display("FAIL missed_state got=pend%b/miss%b required=pend0/miss1", pending_o, err_missed_o);
    else passed++;
    tick();
    checks++;
    if (cnt_ecall_o !== m_ecall) $display("FAIL missed_ecall_count got=%0d required=%0d", cnt_ecall_o, m_ecall);
    else passed++;
  endtask

  task automatic test_mismatch_priority();
    is_ibus_buserr = 1'b1;
    is_instr_illegal = 1'b1;
    wb_pc = 32'h0000_3000;
    tick();
    clear_inputs();
    checks++;
    if (exp_cause_o !== 5'd1) $display("FAIL priority_exp_cause got=%0d required=1", exp_cause_o);
    else passed++;
    trap_taken = 1'b1; trap_mcause = 32'd2; trap_mepc = 32'h0000_3000;
    expect_pulse(n_edge + 1, M_MISMATCH);
    tick();
    clear_inputs();
    tick();
    checks++;
    if (cnt_buserr_o !== m_buserr || cnt_illegal_o !== m_illegal || pending_o !== 1'b0)
      $display("FAIL mismatch_no_count got=%0d/%0d/%b required=%0d/%0d/0",
               cnt_buserr_o, cnt_illegal_o, pending_o, m_buserr, m_illegal);
    else passed++;
  endtask

  task automatic test_spurious();
    trap_taken = 1'b1; trap_mcause = 32'd3; trap_mepc = 32'h0000_0040;
    expect_pulse(n_edge + 1, M_SPURIOUS);
    tick();
    // Interrupt trap: ignored, no pulse expected
    trap_mcause = 32'h8000_000B;
    tick();
    clear_inputs();
    tick();
    checks++;
    if (pending_o !== 1'b0) $display("FAIL interrupt_ignored got=%b required=0", pending_o);
    else passed++;
  endtask

  task automatic test_overlap();
    is_instr_illegal = 1'b1;
    wb_pc = 32'h0000_4000;
    tick();
    clear_inputs();
    is_instr_ebreak = 1'b1;
    wb_pc = 32'h0000_4004;
    expect_pulse(n_edge + 1, M_OVERLAP);
    tick();
    clear_inputs();
    checks++;
    if (pending_o !== 1'b1 || exp_cause_o !== 5'd2)
      $display("FAIL overlap_keeps_capture got=%b/%0d required=1/2", pending_o, exp_cause_o);
    else passed++;
    trap_taken = 1'b1; trap_mcause = 32'd2; trap_mepc = 32'h0000_4000;
    tick();
    clear_inputs();
    m_illegal++;
    checks++;
    if (cnt_illegal_o !== m_illegal || cnt_ebreak_o !== m_ebreak)
      $display("FAIL overlap_count got=%0d/%0d required=%0d/%0d", cnt_illegal_o, cnt_ebreak_o, m_illegal, m_ebreak);
    else passed++;
  endtask

  task automatic test_debug_drop_and_same_cycle();
    is_instr_ebreak = 1'b1;
    ebreak_to_debug = 1'b1;
    wb_pc = 32'h0000_5000;
    tick();
    clear_inputs();
    checks++;
    if (pending_o !== 1'b0 || cnt_ebreak_o !== m_ebreak)
      $display("FAIL debug_drop got=%b/%0d required=0/%0d", pending_o, cnt_ebreak_o, m_ebreak);
    else passed++;
    // ebreak with its trap in the same cycle: direct match from IDLE
    is_instr_ebreak = 1'b1;
    wb_pc = 32'h0000_5008;
    trap_taken = 1'b1; trap_mcause = 32'd3; trap_mepc = 32'h0000_5008;
    tick();
    clear_inputs();
    m_ebreak++;
    checks++;
    if (cnt_ebreak_o !== m_ebreak || pending_o !== 1'b0)
      $display("FAIL same_cycle_match got=%0d/%b required=%0d/0", cnt_ebreak_o, pending_o, m_ebreak);
    else passed++;
    // same-cycle trap with a wrong mepc
    is_instr_illegal = 1'b1;
    wb_pc = 32'h0000_500C;
    trap_taken = 1'b1; trap_mcause = 32'd2; trap_mepc = 32'h0000_5010;
    expect_pulse(n_edge + 1, M_MISMATCH);
    tick();
    clear_inputs();
    tick();
    checks++;
    if (cnt_illegal_o !== m_illegal) $display("FAIL same_cycle_mismatch_count got=%0d required=%0d", cnt_illegal_o, m_illegal);
    else passed++;
  endtask

  task automatic test_timeout_boundary();
    is_ibus_buserr = 1'b1;
    wb_pc = 32'h0000_6000;
    tick();
    clear_inputs();
    repeat (TIMEOUT - 1) tick();
    checks++;
    if (pending_o !== 1'b1) $display("FAIL boundary_still_pending got=%b required=1", pending_o);
    else passed++;
    trap_taken = 1'b1; trap_mcause = 32'd1; trap_mepc = 32'h0000_6000;
    tick();
    clear_inputs();
    m_buserr++;
    tick();
    checks++;
    if (cnt_buserr_o !== m_buserr || pending_o !== 1'b0)
      $display("FAIL boundary_trap_wins got=%0d/%b required=%0d/0", cnt_buserr_o, pending_o, m_buserr);
    else passed++;
  endtask

  task automatic test_reset_mid_pending();
    is_instr_ecall = 1'b1;
    wb_pc = 32'h0000_7000;
    tick();
    clear_inputs();
    tick();
    rst_ni = 1'b0;
    #1;
    m_buserr = '0; m_illegal = '0; m_ecall = '0; m_ebreak = '0;
    checks++;
    if (pending_o !== 1'b0 || exp_cause_o !== 5'd0)
      $display("FAIL async_reset_pending got=%b/%0d required=0/0", pending_o, exp_cause_o);
    else passed++;
    checks++;
    if ({cnt_buserr_o, cnt_illegal_o, cnt_ecall_o, cnt_ebreak_o} !== '0)
      $display("FAIL async_reset_counters got=%h/%h/%h/%h required=0",
               cnt_buserr_o, cnt_illegal_o, cnt_ecall_o, cnt_ebreak_o);
    else passed++;
    tick();
    rst_ni = 1'b1;
    repeat (TIMEOUT + 2) tick();
  endtask

  task automatic test_saturation();
    is_instr_ecall = 1'b1;
    trap_taken = 1'b1;
    trap_mcause = 32'd11;
    for (int i = 0; i < 65535; i++) begin
      wb_pc = 32'h0001_0000 + 32'(i << 2);
      trap_mepc = wb_pc;
      tick();
    end
    checks++;
    if (cnt_ecall_o !== 16'hFFFF) $display("FAIL sat_reach got=%h required=ffff", cnt_ecall_o);
    else passed++;
    repeat (5) tick();
    clear_inputs();
    tick();
    checks++;
    if (cnt_ecall_o !== 16'hFFFF || pending_o !== 1'b0)
      $display("FAIL sat_hold got=%h/%b required=ffff/0", cnt_ecall_o, pending_o);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_illegal_match();
    test_missed();
    test_mismatch_priority();
    test_spurious();
    test_overlap();
    test_debug_drop_and_same_cycle();
    test_timeout_boundary();
    test_reset_mid_pending();
    test_saturation();
    repeat (3) tick();
    checks++;
    if (sb_q.size() != 0) $display("FAIL scoreboard_drain got=%0d required=0", sb_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
